// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: burst request, upstream FIFO read port,
// downstream valid/ready stream and status flags.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  fifo_empty;
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output start, burst_len, fifo_empty, fifo_data, m_ready,
    input  fifo_rden, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    input  start, burst_len, fifo_empty, fifo_data, m_ready,
    output fifo_rden, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a requested number of words from a registered-output FIFO and streams them
// downstream through a 2-entry skid buffer, tagging the final word with m_last.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_burst_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  xfer_left_q, xfer_left_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;

  logic       rden;
  logic       pop;
  logic       wr;
  logic [1:0] occ_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      issue_left_q    <= '0;
      xfer_left_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= '0;
      data0_q         <= '0;
      data1_q         <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_left_q    <= issue_left_d;
      xfer_left_q     <= xfer_left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      data0_q         <= data0_d;
      data1_q         <= data1_d;
      last0_q         <= last0_d;
      last1_q         <= last1_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    issue_left_d    = issue_left_q;
    xfer_left_d     = xfer_left_q;
    count_d         = count_q;
    data0_d         = data0_q;
    data1_d         = data1_q;
    last0_d         = last0_q;
    last1_d         = last1_q;
    rden            = 1'b0;
    pop             = (count_q != 2'd0) && bus.m_ready;
    wr              = inflight_q;
    // A head pop this cycle frees a slot, so it is credited before the
    // occupancy test; without this the stream stalls every other cycle.
    occ_eff         = count_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.burst_len != '0)) begin
          state_d      = ISSUE;
          issue_left_d = bus.burst_len;
          xfer_left_d  = bus.burst_len;
        end
      end
      ISSUE: begin
        if (!bus.fifo_empty && (issue_left_q != '0) && (occ_eff < 2'd2)) begin
          rden         = 1'b1;
          issue_left_d = issue_left_q - LEN_WIDTH'(1);
          if (issue_left_q == LEN_WIDTH'(1)) state_d = FLUSH;
        end
      end
      FLUSH:   ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop && (xfer_left_q != '0)) begin
      xfer_left_d = xfer_left_q - LEN_WIDTH'(1);
      if ((state_q == FLUSH) && (xfer_left_q == LEN_WIDTH'(1))) state_d = DONE;
    end

    inflight_d      = rden;
    inflight_last_d = rden && (issue_left_q == LEN_WIDTH'(1));

    if (wr && pop) begin
      if (count_q == 2'd2) begin
        data0_d = data1_q;
        last0_d = last1_q;
        data1_d = bus.fifo_data;
        last1_d = inflight_last_q;
      end else begin
        data0_d = bus.fifo_data;
        last0_d = inflight_last_q;
      end
    end else if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
      count_d = count_q - 2'd1;
    end else if (wr) begin
      if (count_q == 2'd0) begin
        data0_d = bus.fifo_data;
        last0_d = inflight_last_q;
      end else begin
        data1_d = bus.fifo_data;
        last1_d = inflight_last_q;
      end
      count_d = count_q + 2'd1;
    end
  end

  assign bus.fifo_rden = rden;
  assign bus.m_valid   = (count_q != 2'd0);
  assign bus.m_data    = data0_q;
  assign bus.m_last    = last0_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a registered-output FIFO model and a
// stream scoreboard.
module tb_fifo_burst_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic clk;
  logic rst;
  logic stall;

  int checks = 0;
  int errors = 0;

  fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rden_cnt = 0;
  int underflow = 0;

  assign bus.fifo_empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rden) begin
      rden_cnt <= rden_cnt + 1;
      if (rd_ptr == wr_ptr) underflow <= underflow + 1;
      else begin
        bus.fifo_data <= fifo_mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  logic [DW-1:0] rx_data [0:1023];
  logic          rx_last [0:1023];
  int            rx_cnt = 0;
  int            done_cnt = 0;
  int            hold_err = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;

  always @(posedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      rx_data[rx_cnt] <= bus.m_data;
      rx_last[rx_cnt] <= bus.m_last;
      rx_cnt          <= rx_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    if (hold_pend && bus.m_valid && ((bus.m_data != hold_data) || (bus.m_last != hold_last)))
      hold_err <= hold_err + 1;
    hold_pend <= bus.m_valid && !bus.m_ready;
    hold_data <= bus.m_data;
    hold_last <= bus.m_last;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = first + DW'(i);
      wr_ptr++;
    end
  endtask

  task automatic pulse_start(input logic [LW-1:0] len);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.burst_len = len;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.burst_len = '0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc, input bit rand_ready);
    int n = 0;
    while (bus.busy && (n < max_cyc)) begin
      @(negedge clk);
      if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check({tag, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_burst(input string tag, input int base, input int n,
                             input logic [DW-1:0] first);
    logic [DW-1:0] exp_w;
    check({tag, "_count"}, 32'(rx_cnt - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      exp_w = first + DW'(i);
      check($sformatf("%s_data%0d", tag, i), 32'(rx_data[base + i]), 32'(exp_w));
      check($sformatf("%s_last%0d", tag, i), 32'(rx_last[base + i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    int rx0, rd0, dn0, n;

    rst = 1'b1;
    stall = 1'b0;
    bus.start = 1'b0;
    bus.burst_len = '0;
    bus.m_ready = 1'b0;
    bus.fifo_data = '0;
    repeat (2) @(negedge clk);
    check("rst_rden",  32'(bus.fifo_rden), 0);
    check("rst_valid", 32'(bus.m_valid), 0);
    check("rst_data",  32'(bus.m_data), 0);
    check("rst_last",  32'(bus.m_last), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    rst = 1'b0;

    // Streaming, cycle-exact
    push_seq(8'h11, 4);
    bus.m_ready = 1'b1;
    rx0 = rx_cnt; dn0 = done_cnt;
    pulse_start(8'd4);
    check("s_rden_c1", 32'(bus.fifo_rden), 1);
    check("s_busy_c1", 32'(bus.busy), 1);
    @(negedge clk);
    check("s_valid_c1", 32'(bus.m_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("s_valid_c%0d", i + 2), 32'(bus.m_valid), 1);
      check($sformatf("s_data_c%0d", i + 2), 32'(bus.m_data), 32'(8'h11 + i));
      check($sformatf("s_last_c%0d", i + 2), 32'(bus.m_last), 32'(i == 3));
    end
    @(negedge clk);
    check("s_done_c6", 32'(bus.done), 1);
    check("s_valid_c6", 32'(bus.m_valid), 0);
    @(negedge clk);
    check("s_done_c7", 32'(bus.done), 0);
    check("s_busy_c7", 32'(bus.busy), 0);
    check_burst("s", rx0, 4, 8'h11);
    check("s_donecnt", 32'(done_cnt - dn0), 1);

    // Backpressure
    push_seq(8'h21, 3);
    bus.m_ready = 1'b0;
    rx0 = rx_cnt; rd0 = rden_cnt; dn0 = done_cnt;
    pulse_start(8'd3);
    repeat (4) @(negedge clk);
    check("bp_rden2", 32'(rden_cnt - rd0), 2);
    check("bp_valid", 32'(bus.m_valid), 1);
    check("bp_hold",  32'(bus.m_data), 32'h21);
    bus.m_ready = 1'b1;
    wait_idle("bp", 30, 1'b0);
    check_burst("bp", rx0, 3, 8'h21);
    check("bp_rden3", 32'(rden_cnt - rd0), 3);
    check("bp_donecnt", 32'(done_cnt - dn0), 1);

    // Underflow stall
    stall = 1'b1;
    push_seq(8'h31, 2);
    rx0 = rx_cnt; rd0 = rden_cnt;
    pulse_start(8'd2);
    repeat (3) @(negedge clk);
    check("uf_rden", 32'(rden_cnt - rd0), 0);
    check("uf_busy", 32'(bus.busy), 1);
    stall = 1'b0;
    wait_idle("uf", 30, 1'b0);
    check_burst("uf", rx0, 2, 8'h31);

    // Ignored requests
    pulse_start(8'd0);
    check("ig_len0_busy", 32'(bus.busy), 0);
    push_seq(8'h41, 5);
    rx0 = rx_cnt; dn0 = done_cnt;
    pulse_start(8'd5);
    @(negedge clk);
    bus.start = 1'b1; bus.burst_len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.burst_len = '0;
    wait_idle("ig", 40, 1'b0);
    repeat (3) @(negedge clk);
    check("ig_busy", 32'(bus.busy), 0);
    check_burst("ig", rx0, 5, 8'h41);
    check("ig_donecnt", 32'(done_cnt - dn0), 1);

    // Reset mid-burst
    push_seq(8'h51, 6);
    rx0 = rx_cnt;
    pulse_start(8'd6);
    n = 0;
    while ((rx_cnt - rx0 < 2) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("rm_two_words", 32'(rx_cnt - rx0), 2);
    rst = 1'b1;
    #1;
    check("rm_rden",  32'(bus.fifo_rden), 0);
    check("rm_valid", 32'(bus.m_valid), 0);
    check("rm_data",  32'(bus.m_data), 0);
    check("rm_last",  32'(bus.m_last), 0);
    check("rm_busy",  32'(bus.busy), 0);
    check("rm_done",  32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rm_novalid%0d", i), 32'(bus.m_valid), 0);
    end
    check("rm_nomore", 32'(rx_cnt - rx0), 2);
    push_seq(8'h5A, 1);
    rx0 = rx_cnt; dn0 = done_cnt;
    pulse_start(8'd1);
    wait_idle("rm_new", 20, 1'b0);
    check_burst("rm_new", rx0, 1, 8'h5A);
    check("rm_new_donecnt", 32'(done_cnt - dn0), 1);

    // Max length with random backpressure
    push_seq(8'h00, 255);
    rx0 = rx_cnt; rd0 = rden_cnt; dn0 = done_cnt;
    pulse_start(8'd255);
    wait_idle("max", 4000, 1'b1);
    bus.m_ready = 1'b1;
    check_burst("max", rx0, 255, 8'h00);
    check("max_rden", 32'(rden_cnt - rd0), 255);
    check("max_donecnt", 32'(done_cnt - dn0), 1);

    check("hold_stable", 32'(hold_err), 0);
    check("fifo_underflow", 32'(underflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
